// File: rtl/vector_binop_pkg.sv
// ---------------------------------------------------------------------------
// vector_binop_pkg
// Shared types for the vector binary-op engine: controller state encoding and
// the OP field encodings used by the engine and its ALU.
// Optional build macro used by the engine/ALU: VECTOR_BINOP_SAT_EN.
// ---------------------------------------------------------------------------
package vector_binop_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RW0,
    S_GAP0,
    S_RD1,
    S_RW1,
    S_CALC,
    S_WR,
    S_WW,
    S_FIN
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;  // src0 - src1
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

endpackage

// File: rtl/vector_binop_alu.sv
// ---------------------------------------------------------------------------
// vector_binop_alu
// Combinational element-wise operation for the vector engine.
// Build macro: VECTOR_BINOP_SAT_EN -- when defined, add/sub saturate as
// unsigned (add clamps to all-ones, sub clamps to zero) and sat_o reports a
// clamp; otherwise arithmetic wraps modulo 2^WD and sat_o does not exist.
// Ports:
//   op_i   OP encoding (OP_ADD/OP_SUB/OP_AND/OP_XOR)
//   a_i    operand 0 (src0 element)
//   b_i    operand 1 (src1 element)
//   sat_o  result was clamped (saturating build only)
//   y_o    result
// ---------------------------------------------------------------------------
module vector_binop_alu
  import vector_binop_pkg::*;
#(
  parameter int WD = 32
) (
  input  logic [1:0]    op_i,
  input  logic [WD-1:0] a_i,
  input  logic [WD-1:0] b_i,
`ifdef VECTOR_BINOP_SAT_EN
  output logic          sat_o,
`endif
  output logic [WD-1:0] y_o
);

`ifdef VECTOR_BINOP_SAT_EN
  // One extra bit exposes carry-out (add) and borrow (sub).
  logic [WD:0] sum_w;
  logic [WD:0] dif_w;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i};
  assign dif_w = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    y_o   = '0;
    sat_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o   = sum_w[WD] ? '1 : sum_w[WD-1:0];
        sat_o = sum_w[WD];
      end
      OP_SUB: begin
        y_o   = dif_w[WD] ? '0 : dif_w[WD-1:0];
        sat_o = dif_w[WD];
      end
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end
`else
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end
`endif

endmodule

// File: rtl/vector_binop_engine.sv
// ---------------------------------------------------------------------------
// vector_binop_engine
// Bus master that streams two source vectors from a single-port memory,
// applies an element-wise binary op and writes the result vector back.
// Per element: read src0, read src1, compute, write dst.
// Build macro: VECTOR_BINOP_SAT_EN -- saturating add/sub plus a sticky SAT
// output; undefined gives modulo arithmetic and no SAT port.
// Ports:
//   CLK, RST              clock, async active-high reset
//   START, ABORT          run request (IDLE only) / early-stop level
//   OP, *_BASE, LEN       run configuration, latched on accepted START
//   BUSY, DONE, ABORTED   run status; ABORTED is valid with DONE and held
//   COUNT                 elements fully written in the current/last run
//   SAT                   sticky clamp flag (saturating build only)
//   MEM_A/RE/WE/D         memory request
//   MEM_Q/BUSY/DONE       memory response
// ---------------------------------------------------------------------------
module vector_binop_engine
  import vector_binop_pkg::*;
#(
  parameter int WA   = 32,
  parameter int WD   = 32,
  parameter int STEP = 32,
  parameter int WL   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [1:0]    OP,
  input  logic [WA-1:0] SRC0_BASE,
  input  logic [WA-1:0] SRC1_BASE,
  input  logic [WA-1:0] DST_BASE,
  input  logic [WL-1:0] LEN,
  output logic          BUSY,
  output logic          DONE,
  output logic          ABORTED,
  output logic [WL-1:0] COUNT,
`ifdef VECTOR_BINOP_SAT_EN
  output logic          SAT,
`endif
  output logic [WA-1:0] MEM_A,
  output logic          MEM_RE,
  output logic          MEM_WE,
  output logic [WD-1:0] MEM_D,
  input  logic [WD-1:0] MEM_Q,
  input  logic          MEM_BUSY,
  input  logic          MEM_DONE
);

  state_e        state_q, state_d;
  logic [1:0]    op_q;
  logic [WA-1:0] src0_q, src1_q, dst_q;
  logic [WL-1:0] len_q, idx_q, count_q;
  logic [WD-1:0] op0_q, op1_q, wdata_q;
  logic          busy_q, done_q, aborted_q;

  logic          start_ok;
  logic          pending;
  logic          wr_done;
  logic [WL-1:0] idx_inc;
  logic          last_elem;
  logic [WA-1:0] offset;
  logic [WD-1:0] alu_y;
`ifdef VECTOR_BINOP_SAT_EN
  logic          alu_sat;
  logic          sat_q;
`endif

  // A START is only seen in IDLE with no run in flight. busy_q in IDLE means
  // a run is waiting for the bus to go idle before issuing its next read.
  assign start_ok  = (state_q == S_IDLE) && !busy_q && START;
  assign pending   = (state_q == S_IDLE) && busy_q;
  assign wr_done   = (state_q == S_WW) && MEM_DONE;
  assign idx_inc   = idx_q + WL'(1);
  assign last_elem = (idx_inc == len_q);
  assign offset    = WA'(idx_q) * WA'(STEP);

  vector_binop_alu #(.WD(WD)) u_alu (
    .op_i  (op_q),
    .a_i   (op0_q),
    .b_i   (op1_q),
`ifdef VECTOR_BINOP_SAT_EN
    .sat_o (alu_sat),
`endif
    .y_o   (alu_y)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. Strobe states are entered only with the bus idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pending) begin
          if (ABORT)         state_d = S_FIN;
          else if (!MEM_BUSY) state_d = S_RD0;
        end else if (start_ok) begin
          if (LEN == '0)      state_d = S_FIN;
          else if (!MEM_BUSY) state_d = S_RD0;
        end
      end
      S_RD0:  if (MEM_BUSY)  state_d = S_RW0;
      S_RW0:  if (MEM_DONE)  state_d = S_GAP0;
      S_GAP0: if (!MEM_BUSY) state_d = S_RD1;
      S_RD1:  if (MEM_BUSY)  state_d = S_RW1;
      S_RW1:  if (MEM_DONE)  state_d = S_CALC;
      S_CALC: if (!MEM_BUSY) state_d = S_WR;
      S_WR:   if (MEM_BUSY)  state_d = S_WW;
      S_WW: begin
        if (MEM_DONE) begin
          if (last_elem || ABORT) state_d = S_FIN;
          else if (!MEM_BUSY)     state_d = S_RD0;
          else                    state_d = S_IDLE;  // park until bus frees
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes and address decode straight from the state register so
  // that reset removes them without waiting for a clock.
  always_comb begin
    MEM_RE = 1'b0;
    MEM_WE = 1'b0;
    MEM_A  = '0;
    case (state_q)
      S_RD0: begin MEM_RE = 1'b1; MEM_A = src0_q + offset; end
      S_RD1: begin MEM_RE = 1'b1; MEM_A = src1_q + offset; end
      S_WR:  begin MEM_WE = 1'b1; MEM_A = dst_q  + offset; end
      default: ;
    endcase
  end

  // Run configuration and element datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q      <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      op0_q     <= '0;
      op1_q     <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef VECTOR_BINOP_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      done_q <= (state_q == S_FIN);
      if (start_ok) begin
        op_q      <= OP;
        src0_q    <= SRC0_BASE;
        src1_q    <= SRC1_BASE;
        dst_q     <= DST_BASE;
        len_q     <= LEN;
        idx_q     <= '0;
        count_q   <= '0;
        busy_q    <= 1'b1;
        aborted_q <= 1'b0;
`ifdef VECTOR_BINOP_SAT_EN
        sat_q     <= 1'b0;
`endif
      end
      if (pending && ABORT) aborted_q <= 1'b1;
      if (state_q == S_RW0 && MEM_DONE) op0_q <= MEM_Q;
      if (state_q == S_RW1 && MEM_DONE) op1_q <= MEM_Q;
      if (state_q == S_CALC) begin
        wdata_q <= alu_y;
`ifdef VECTOR_BINOP_SAT_EN
        sat_q   <= sat_q | alu_sat;
`endif
      end
      if (wr_done) begin
        idx_q   <= idx_inc;
        count_q <= count_q + WL'(1);
        if (!last_elem && ABORT) aborted_q <= 1'b1;
      end
      if (state_q == S_FIN) busy_q <= 1'b0;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ABORTED = aborted_q;
  assign COUNT   = count_q;
  assign MEM_D   = wdata_q;
`ifdef VECTOR_BINOP_SAT_EN
  assign SAT     = sat_q;
`endif

endmodule

// File: tb/tb_vector_binop_engine.sv
// ---------------------------------------------------------------------------
// tb_vector_binop_engine
// Directed bench for vector_binop_engine with a one-request-at-a-time memory
// model (MEM_BUSY the cycle after a strobe, MEM_DONE the cycle after that).
// Source data comes from src0_tab/src1_tab selected by address bits; writes
// are logged in order. Honors VECTOR_BINOP_SAT_EN for SAT expectations.
// ---------------------------------------------------------------------------
module tb_vector_binop_engine;
  import vector_binop_pkg::*;

  localparam int WA = 32, WD = 32, STEP = 32, WL = 16;

  logic          CLK = 1'b0, RST = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic [1:0]    OP = 2'd0;
  logic [WA-1:0] SRC0_BASE = '0, SRC1_BASE = '0, DST_BASE = '0;
  logic [WL-1:0] LEN = '0;
  logic          BUSY, DONE, ABORTED;
  logic [WL-1:0] COUNT;
`ifdef VECTOR_BINOP_SAT_EN
  logic          SAT;
`endif
  logic [WA-1:0] MEM_A;
  logic          MEM_RE, MEM_WE;
  logic [WD-1:0] MEM_D, MEM_Q;
  logic          MEM_BUSY, MEM_DONE;

  vector_binop_engine #(.WA(WA), .WD(WD), .STEP(STEP), .WL(WL)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .OP(OP),
    .SRC0_BASE(SRC0_BASE), .SRC1_BASE(SRC1_BASE), .DST_BASE(DST_BASE),
    .LEN(LEN), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED), .COUNT(COUNT),
`ifdef VECTOR_BINOP_SAT_EN
    .SAT(SAT),
`endif
    .MEM_A(MEM_A), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_D(MEM_D),
    .MEM_Q(MEM_Q), .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  logic [WD-1:0] src0_tab [16];
  logic [WD-1:0] src1_tab [16];
  logic [WA-1:0] wa_log [64];
  logic [WD-1:0] wd_log [64];
  int txn_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic mph;
  logic [WA-1:0] rq_a;

  // Region 0 (0x0000) = src0, region 1 (0x8000) = src1, element = addr[8:5].
  function automatic logic [WD-1:0] rd_word(input logic [WA-1:0] a);
    case (a[16:15])
      2'd0:    return src0_tab[a[8:5]];
      2'd1:    return src1_tab[a[8:5]];
      default: return '0;
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mph <= 1'b0; MEM_BUSY <= 1'b0; MEM_DONE <= 1'b0; MEM_Q <= '0; rq_a <= '0;
    end else if (!mph) begin
      MEM_DONE <= 1'b0;
      if (MEM_RE || MEM_WE) begin
        mph <= 1'b1; MEM_BUSY <= 1'b1; txn_cnt <= txn_cnt + 1; rq_a <= MEM_A;
        if (MEM_WE) begin
          wa_log[wr_cnt[5:0]] <= MEM_A;
          wd_log[wr_cnt[5:0]] <= MEM_D;
          wr_cnt <= wr_cnt + 1;
        end
      end
    end else begin
      mph <= 1'b0; MEM_BUSY <= 1'b0; MEM_DONE <= 1'b1; MEM_Q <= rd_word(rq_a);
    end
  end

  always @(posedge CLK) if (DONE) done_cnt <= done_cnt + 1;

  task automatic start_run(input logic [1:0] op, input logic [WA-1:0] s0,
                           input logic [WA-1:0] s1, input logic [WA-1:0] d,
                           input logic [WL-1:0] len);
    @(negedge CLK);
    OP = op; SRC0_BASE = s0; SRC1_BASE = s1; DST_BASE = d; LEN = len; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (DONE) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
  endtask

  // Runs a single-element job and checks the written value.
  task automatic one_elem(input string nm, input logic [1:0] op,
                          input logic [WD-1:0] a, input logic [WD-1:0] b,
                          input logic [WD-1:0] exp_y);
    bit ok; int w0;
    src0_tab[0] = a; src1_tab[0] = b; w0 = wr_cnt;
    start_run(op, 32'h0, 32'h8000, 32'h10000, 16'd1);
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL %s_done got timeout want DONE", nm); end
    n_cmp++; if (wd_log[w0 % 64] !== exp_y) begin n_bad++; $display("FAIL %s_data got %h want %h", nm, wd_log[w0 % 64], exp_y); end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++; if ({BUSY, DONE, ABORTED, MEM_RE, MEM_WE} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got %b want 00000", {BUSY, DONE, ABORTED, MEM_RE, MEM_WE}); end
    n_cmp++; if (COUNT !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", COUNT); end
    n_cmp++; if ({MEM_A, MEM_D} !== 64'h0) begin n_bad++; $display("FAIL reset_bus got %h want 0", {MEM_A, MEM_D}); end
    RST = 1'b0;
  endtask

  task automatic test_add();
    bit ok; int w0, t0, d0;
    for (int i = 0; i < 16; i++) begin src0_tab[i] = i; src1_tab[i] = 32'h10; end
    w0 = wr_cnt; t0 = txn_cnt; d0 = done_cnt;
    start_run(OP_ADD, 32'h0, 32'h8000, 32'h10000, 16'd4);
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL add_busy got %b want 1", BUSY); end
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL add_done got timeout want DONE"); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL add_busy_end got %b want 0", BUSY); end
    n_cmp++; if (COUNT !== 16'd4) begin n_bad++; $display("FAIL add_count got %0d want 4", COUNT); end
    n_cmp++; if (ABORTED !== 1'b0) begin n_bad++; $display("FAIL add_aborted got %b want 0", ABORTED); end
    n_cmp++; if (txn_cnt - t0 !== 12) begin n_bad++; $display("FAIL add_txns got %0d want 12", txn_cnt - t0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (wd_log[(w0 + i) % 64] !== 32'h10 + i) begin n_bad++; $display("FAIL add_dst%0d got %h want %h", i, wd_log[(w0 + i) % 64], 32'h10 + i); end
      n_cmp++; if (wa_log[(w0 + i) % 64] !== 32'h10000 + 32 * i) begin n_bad++; $display("FAIL add_addr%0d got %h want %h", i, wa_log[(w0 + i) % 64], 32'h10000 + 32 * i); end
    end
    repeat (5) @(negedge CLK);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL add_done_pulses got %0d want 1", done_cnt - d0); end
`ifdef VECTOR_BINOP_SAT_EN
    n_cmp++; if (SAT !== 1'b0) begin n_bad++; $display("FAIL add_sat got %b want 0", SAT); end
`endif
  endtask

  task automatic test_arith();
`ifdef VECTOR_BINOP_SAT_EN
    one_elem("sub", OP_SUB, 32'h5, 32'h7, 32'h0);
    n_cmp++; if (SAT !== 1'b1) begin n_bad++; $display("FAIL sub_sat got %b want 1", SAT); end
    one_elem("addovf", OP_ADD, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
    one_elem("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    n_cmp++; if (SAT !== 1'b0) begin n_bad++; $display("FAIL and_sat got %b want 0", SAT); end
`else
    one_elem("sub", OP_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE);
    one_elem("addovf", OP_ADD, 32'hFFFF_FFFF, 32'h2, 32'h1);
    one_elem("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
`endif
    one_elem("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
  endtask

  task automatic test_len0();
    int t0;
    t0 = txn_cnt;
    @(negedge CLK);
    LEN = '0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n_cmp++; if ({DONE, BUSY} !== 2'b01) begin n_bad++; $display("FAIL len0_c1 got %b want 01", {DONE, BUSY}); end
    @(negedge CLK);
    n_cmp++; if ({DONE, BUSY} !== 2'b10) begin n_bad++; $display("FAIL len0_c2 got %b want 10", {DONE, BUSY}); end
    n_cmp++; if (COUNT !== '0) begin n_bad++; $display("FAIL len0_count got %0d want 0", COUNT); end
    n_cmp++; if (txn_cnt - t0 !== 0) begin n_bad++; $display("FAIL len0_txns got %0d want 0", txn_cnt - t0); end
  endtask

  task automatic test_abort();
    bit ok; int w0, t0;
    for (int i = 0; i < 16; i++) begin src0_tab[i] = i; src1_tab[i] = 32'h10; end
    w0 = wr_cnt; t0 = txn_cnt;
    start_run(OP_ADD, 32'h0, 32'h8000, 32'h10000, 16'd8);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (txn_cnt - t0 >= 8) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_reach got timeout want 8 txns"); end
    ABORT = 1'b1;
    wait_done(ok);
    ABORT = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_done got timeout want DONE"); end
    n_cmp++; if (ABORTED !== 1'b1) begin n_bad++; $display("FAIL abort_flag got %b want 1", ABORTED); end
    n_cmp++; if (COUNT !== 16'd3) begin n_bad++; $display("FAIL abort_count got %0d want 3", COUNT); end
    n_cmp++; if (wr_cnt - w0 !== 3) begin n_bad++; $display("FAIL abort_writes got %0d want 3", wr_cnt - w0); end
    n_cmp++; if (wd_log[(w0 + 2) % 64] !== 32'h12) begin n_bad++; $display("FAIL abort_elem2 got %h want 12", wd_log[(w0 + 2) % 64]); end
    repeat (3) @(negedge CLK);
    n_cmp++; if (ABORTED !== 1'b1) begin n_bad++; $display("FAIL abort_hold got %b want 1", ABORTED); end
  endtask

  task automatic test_wrap();
    bit ok; int w0;
    w0 = wr_cnt;
    start_run(OP_ADD, 32'h0, 32'h8000, 32'hFFFF_FFE0, 16'd2);
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL wrap_done got timeout want DONE"); end
    n_cmp++; if (wa_log[w0 % 64] !== 32'hFFFF_FFE0) begin n_bad++; $display("FAIL wrap_a0 got %h want ffffffe0", wa_log[w0 % 64]); end
    n_cmp++; if (wa_log[(w0 + 1) % 64] !== 32'h0) begin n_bad++; $display("FAIL wrap_a1 got %h want 00000000", wa_log[(w0 + 1) % 64]); end
    n_cmp++; if ({ABORTED, COUNT} !== {1'b0, 16'd2}) begin n_bad++; $display("FAIL wrap_status got %b/%0d want 0/2", ABORTED, COUNT); end
  endtask

  task automatic test_rst_mid();
    bit ok; int w0;
    w0 = wr_cnt;
    start_run(OP_ADD, 32'h0, 32'h8000, 32'h10000, 16'd4);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_cnt - w0 >= 2 && !MEM_WE) begin ok = 1'b1; break; end
      @(negedge CLK);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_reach got timeout want WW"); end
    RST = 1'b1;
    #1;
    n_cmp++; if ({BUSY, DONE, MEM_RE, MEM_WE} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {BUSY, DONE, MEM_RE, MEM_WE}); end
    n_cmp++; if (COUNT !== '0) begin n_bad++; $display("FAIL rst_count got %0d want 0", COUNT); end
    n_cmp++; if ({MEM_A, MEM_D} !== 64'h0) begin n_bad++; $display("FAIL rst_bus got %h want 0", {MEM_A, MEM_D}); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok; int w0, t0, d0;
    w0 = wr_cnt; t0 = txn_cnt; d0 = done_cnt;
    start_run(OP_ADD, 32'h0, 32'h8000, 32'h10000, 16'd2);
    repeat (3) @(negedge CLK);
    OP = OP_XOR; DST_BASE = 32'hFFFF_FFE0; LEN = 16'd5; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_done got timeout want DONE"); end
    n_cmp++; if (COUNT !== 16'd2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", COUNT); end
    n_cmp++; if (wd_log[w0 % 64] !== 32'h10 || wd_log[(w0 + 1) % 64] !== 32'h11) begin n_bad++; $display("FAIL b2b_data got %h,%h want 10,11", wd_log[w0 % 64], wd_log[(w0 + 1) % 64]); end
    n_cmp++; if (wa_log[(w0 + 1) % 64] !== 32'h10020) begin n_bad++; $display("FAIL b2b_addr got %h want 10020", wa_log[(w0 + 1) % 64]); end
    repeat (20) @(negedge CLK);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL b2b_done_pulses got %0d want 1", done_cnt - d0); end
    n_cmp++; if (txn_cnt - t0 !== 6) begin n_bad++; $display("FAIL b2b_txns got %0d want 6", txn_cnt - t0); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got %b want 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_len0();
    test_abort();
    test_wrap();
    test_rst_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
